dds_profile_scheduler: RTL



---
 rtl/dds_sched_pkg.sv | 38 +++
 rtl/dds_profile_scheduler_fifo.sv | 54 +++++
 rtl/dds_profile_scheduler.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dds_sched_pkg.sv
// Shared definitions for the DDS profile scheduler: command layout, opcodes
// and output mode encodings.
package dds_sched_pkg;

    localparam int CMD_W     = 128;
    localparam int TS_W      = 64;
    localparam int OP_W      = 4;
    localparam int CH_W      = 4;
    localparam int PAYLOAD_W = 56;
    localparam int TS_LSB    = 64;
    localparam int OP_LSB    = 60;
    localparam int CH_LSB    = 56;
    localparam int STEP_LSB  = 16;

    typedef enum logic [OP_W-1:0] {
        OP_SET_FREQ   = 4'd0,
        OP_SET_AMP    = 4'd1,
        OP_SET_PHASE  = 4'd2,
        OP_SET_OFFSET = 4'd3,
        OP_RAMP_AMP   = 4'd4,
        OP_SET_MODE   = 4'd5,
        OP_SYNC       = 4'd6
    } opcode_e;

    // Opcode kept as raw bits: values 7..15 arrive on the wire and must be rejected.
    typedef struct packed {
        logic [TS_W-1:0]      ts;
        logic [OP_W-1:0]      opcode;
        logic [CH_W-1:0]      ch;
        logic [PAYLOAD_W-1:0] payload;
    } cmd_t;

    localparam logic [1:0] MODE_OFF    = 2'd0;
    localparam logic [1:0] MODE_DDS    = 2'd1;
    localparam logic [1:0] MODE_DIRECT = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

endpackage

// File: rtl/dds_profile_scheduler_fifo.sv
// First-word-fall-through command queue with flush and occupancy count.
module sched_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dds_profile_scheduler.sv
// Timestamped multi-channel DDS profile scheduler: one shared queue, dispatch on
// RTIO time, per-channel profile registers and linear amplitude ramps.
module dds_profile_scheduler
    import dds_sched_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int FREQ_W     = 48,
    parameter int AMP_W      = 14
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          auto_start,
    input  logic [63:0]                   counter,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [127:0]                  cmd_data,
    output logic [NUM_CH*FREQ_W-1:0]      freq_out,
    output logic [NUM_CH*AMP_W-1:0]       amp_out,
    output logic [NUM_CH*AMP_W-1:0]       phase_out,
    output logic [NUM_CH*AMP_W-1:0]       amp_offset_out,
    output logic [NUM_CH*2-1:0]           mode_out,
    output logic [NUM_CH-1:0]             sync_en,
    output logic [NUM_CH-1:0]             ramp_busy,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          timestamp_error,
    output logic                          opcode_error
);
    localparam logic [0:0] RS_IDLE = 1'b0;
    localparam logic [0:0] RS_RAMP = 1'b1;

    logic [CMD_W-1:0] head_raw;
    cmd_t             head;
    logic             dispatch, late, valid_cmd, apply;
    logic             unused_payload;

    sched_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (cmd_valid),
        .pop   (dispatch),
        .wdata (cmd_data),
        .rdata (head_raw),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign head      = head_raw;
    assign cmd_ready = !full;
    assign dispatch  = auto_start && !empty && (counter >= head.ts);
    assign late      = head.ts < counter;
    assign valid_cmd = (head.opcode <= OP_SYNC) && (32'(head.ch) < NUM_CH) &&
                       !(head.opcode == OP_SET_MODE && head.payload[1:0] == MODE_RSVD);
    assign apply     = dispatch && valid_cmd;
    assign unused_payload = ^head.payload;

    // Late commands still pop; the error pulse is independent of validity.
    always_ff @(posedge clk) begin
        if (reset) begin
            timestamp_error <= 1'b0;
            opcode_error    <= 1'b0;
        end else begin
            timestamp_error <= dispatch && late;
            opcode_error    <= dispatch && !valid_cmd;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic              hit, amp_ovr, sync;
        logic [FREQ_W-1:0] freq;
        logic [AMP_W-1:0]  amp, phase, offs, tgt, step;
        logic [AMP_W-1:0]  new_tgt, new_step, amp_next;
        logic [AMP_W:0]    up_sum;
        logic [1:0]        mode;
        logic [0:0]        rstate;

        assign hit      = apply && (head.ch == CH_W'(i));
        assign amp_ovr  = hit && (head.opcode == OP_SET_AMP || head.opcode == OP_RAMP_AMP);
        assign new_tgt  = head.payload[AMP_W-1:0];
        assign new_step = head.payload[STEP_LSB+AMP_W-1:STEP_LSB];

        // One extra bit on the way up so amp+step cannot wrap past the target.
        always_comb begin
            up_sum = {1'b0, amp} + {1'b0, step};
            if (amp < tgt)
                amp_next = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[AMP_W-1:0];
            else
                amp_next = (step >= amp - tgt) ? tgt : amp - step;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                freq   <= '0;
                amp    <= '0;
                phase  <= '0;
                offs   <= '0;
                tgt    <= '0;
                step   <= '0;
                mode   <= MODE_OFF;
                sync   <= 1'b0;
                rstate <= RS_IDLE;
            end else begin
                sync <= hit && (head.opcode == OP_SYNC);
                if (hit) begin
                    case (head.opcode)
                        OP_SET_FREQ:   freq  <= head.payload[FREQ_W-1:0];
                        OP_SET_PHASE:  phase <= new_tgt;
                        OP_SET_OFFSET: offs  <= new_tgt;
                        OP_SET_MODE:   mode  <= head.payload[1:0];
                        OP_SET_AMP: begin
                            amp    <= new_tgt;
                            rstate <= RS_IDLE;
                        end
                        OP_RAMP_AMP: begin
                            tgt  <= new_tgt;
                            step <= new_step;
                            if (new_step == '0 || amp == new_tgt) begin
                                amp    <= new_tgt;
                                rstate <= RS_IDLE;
                            end else begin
                                rstate <= RS_RAMP;
                            end
                        end
                        default: ;
                    endcase
                end
                // A dispatched amplitude command replaces this cycle's step.
                if (rstate == RS_RAMP && !amp_ovr) begin
                    amp <= amp_next;
                    if (amp_next == tgt) rstate <= RS_IDLE;
                end
            end
        end

        assign freq_out[i*FREQ_W +: FREQ_W]      = freq;
        assign amp_out[i*AMP_W +: AMP_W]         = amp;
        assign phase_out[i*AMP_W +: AMP_W]       = phase;
        assign amp_offset_out[i*AMP_W +: AMP_W]  = offs;
        assign mode_out[i*2 +: 2]                = mode;
        assign sync_en[i]                        = sync;
        assign ramp_busy[i]                      = (rstate == RS_RAMP);
    end

endmodule
